display_writer: RTL

DISPLAY_WRITER -- requirements
Module: display_writer

---
 rtl/display_pkg.sv | 28 ++
 rtl/bin2bcd_step.sv | 21 ++
 rtl/display_writer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the eight-digit display writer: FSM encoding,
// digit count, conversion width, saturation limit and DIN field layout.
package display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONV  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int          DIGITS  = 8;
   localparam int          VALUE_W = 27;
   localparam int unsigned MAX_VAL = 99_999_999;
   localparam int          BCD_W   = 4 * DIGITS;

   // DIN field positions
   localparam int EN_BIT  = 5;
   localparam int BCD_MSB = 4;
   localparam int BCD_LSB = 1;
   localparam int DP_BIT  = 0;

   // Double-dabble nibble correction applied before each shift.
   function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

endpackage

// File: rtl/bin2bcd_step.sv
// One double-dabble iteration: correct every BCD nibble, then shift the
// next binary bit (MSB first) into the bottom of the BCD register.
module bin2bcd_step (
   input  logic [31:0] bcd_in,
   input  logic        bit_in,
   output logic [31:0] bcd_out
);
   import display_pkg::*;

   logic [31:0] adj;

   // Nibble correction followed by a one-bit left shift.
   always_comb begin
      adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         adj[4*i +: 4] = dd_adjust(bcd_in[4*i +: 4]);
      end
      bcd_out = {adj[30:0], bit_in};
   end

endmodule

// File: rtl/display_writer.sv
// Converts a binary value to eight BCD digits (one bit per cycle) and
// writes them, with optional leading-zero blanking and a decimal point,
// into the display RAM through the W/WADD/DIN port.
//
// Handshake: start is a request qualified only by busy=0; a request seen
// while busy=1 is dropped. busy stays high from the cycle after the
// accepted start through the cycle done pulses, so a held start begins
// the next conversion in the IDLE cycle right after DONE.
module display_writer #(
   parameter int BLANK_EN = 1,
   parameter int VALUE_W  = 27
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [VALUE_W-1:0] value,
   input  logic               dp_en,
   input  logic [2:0]         dp_pos,
   output logic               busy,
   output logic               done,
   output logic               ovf,
   output logic               W,
   output logic [2:0]         WADD,
   output logic [5:0]         DIN
);
   import display_pkg::*;

   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] CONV  = ST_CONV;
   localparam logic [1:0] WRITE = ST_WRITE;
   localparam logic [1:0] DONE  = ST_DONE;

   localparam int               CNT_W    = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);
   localparam logic [63:0]      MAX64    = 64'(MAX_VAL);

   logic [1:0]         state_q,  state_d;
   logic [VALUE_W-1:0] bin_q,    bin_d;
   logic [31:0]        bcd_q,    bcd_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic               dp_en_q,  dp_en_d;
   logic [2:0]         dp_pos_q, dp_pos_d;
   logic               ovf_q,    ovf_d;
   logic               w_q,      w_d;
   logic [2:0]         wadd_q,   wadd_d;
   logic [5:0]         din_q,    din_d;

   logic [31:0]        step_bcd;
   logic [31:0]        src_bcd;
   logic [63:0]        value_ext;
   logic               over;
   logic [VALUE_W-1:0] value_sat;
   logic [2:0]         msd;
   logic [2:0]         limit;
   logic [2:0]         nxt_idx;
   logic [3:0]         nxt_nib;
   logic [5:0]         din_nxt;

   bin2bcd_step u_step (
      .bcd_in  (bcd_q),
      .bit_in  (bin_q[VALUE_W-1]),
      .bcd_out (step_bcd)
   );

   // Saturate the incoming value at the largest eight-digit number.
   always_comb begin
      value_ext = 64'(value);
      over      = (value_ext > MAX64);
      value_sat = over ? VALUE_W'(MAX64) : value;
   end

   // Digit data for the next write; the first write uses the final
   // conversion step directly so W lines up with the WRITE state.
   always_comb begin
      src_bcd = (state_q == CONV) ? step_bcd : bcd_q;
      msd     = 3'd0;
      for (int i = 1; i < DIGITS; i++) begin
         if (src_bcd[4*i +: 4] != 4'd0) msd = 3'(i);
      end
      limit   = (dp_en_q && (dp_pos_q > msd)) ? dp_pos_q : msd;
      nxt_idx = (state_q == CONV) ? 3'd0 : wadd_q + 3'd1;
      nxt_nib = src_bcd[{nxt_idx, 2'b00} +: 4];
      din_nxt = '0;
      din_nxt[EN_BIT]          = (BLANK_EN == 0) || (nxt_idx == 3'd0) || (nxt_idx <= limit);
      din_nxt[BCD_MSB:BCD_LSB] = nxt_nib;
      din_nxt[DP_BIT]          = dp_en_q && (nxt_idx == dp_pos_q);
   end

   // Sequencing: accept, convert VALUE_W bits, write eight digits, pulse done.
   always_comb begin
      state_d  = state_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      dp_en_d  = dp_en_q;
      dp_pos_d = dp_pos_q;
      ovf_d    = ovf_q;
      w_d      = 1'b0;
      wadd_d   = wadd_q;
      din_d    = din_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d    = value_sat;
               bcd_d    = '0;
               cnt_d    = '0;
               dp_en_d  = dp_en;
               dp_pos_d = dp_pos;
               ovf_d    = over;
               state_d  = CONV;
            end
         end
         CONV: begin
            bcd_d = step_bcd;
            bin_d = bin_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = WRITE;
               w_d     = 1'b1;
               wadd_d  = 3'd0;
               din_d   = din_nxt;
            end
         end
         WRITE: begin
            if (wadd_q == 3'd7) begin
               state_d = DONE;
            end else begin
               w_d    = 1'b1;
               wadd_d = nxt_idx;
               din_d  = din_nxt;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered write port, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         dp_en_q  <= 1'b0;
         dp_pos_q <= 3'd0;
         ovf_q    <= 1'b0;
         w_q      <= 1'b0;
         wadd_q   <= 3'd0;
         din_q    <= 6'd0;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         dp_en_q  <= dp_en_d;
         dp_pos_q <= dp_pos_d;
         ovf_q    <= ovf_d;
         w_q      <= w_d;
         wadd_q   <= wadd_d;
         din_q    <= din_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign ovf  = ovf_q;
   assign W    = w_q;
   assign WADD = wadd_q;
   assign DIN  = din_q;

endmodule
